f_stage: RTL and testbench

Instruction fetch stage: holds the program counter, issues one instruction-memory read at a time, and presents the fetched instruction and its PC to the decode stage through the IF/ID pipeline register. It sits directly upstream of `d_stage`. It honours the decode-stage `stall`, and accepts a redirect (taken branch or jump target) from execute. Bubbles are delivered as the canonical NOP.

---
 rtl/rv_pkg.sv | 23 ++
 rtl/f_stage.sv | 157 +++++++++++++++
 tb/tb_f_stage.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, the canonical NOP word
// used to fill bubbles, and the default reset fetch address.
package rv_pkg;

    // Fetch FSM states.
    //   IDLE  : nothing outstanding, a request may be issued
    //   WAIT  : one request outstanding, its response will be used
    //   HOLD  : response parked in the hold buffer while decode stalls
    //   DRAIN : one request outstanding, its response will be dropped
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0 -- also used by the flush logic of later stages.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // First fetch address after reset unless the stage overrides it.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/f_stage.sv
// Instruction fetch stage. Keeps the program counter, issues one
// instruction-memory read at a time and loads the IF/ID register that feeds
// the decode stage. Decode stalls freeze IF/ID; a redirect from execute
// flushes the stream (bubble = NOP, valid_out = 0) and restarts at the target.
//
// Instruction-memory handshake: imem_req is a one-cycle pulse with
// imem_addr valid in the same cycle; there is no ready, the memory must
// accept every pulse. Exactly one imem_rvalid pulse answers each request,
// one or more cycles later, with imem_rdata valid in that cycle. Only one
// request is ever outstanding. A request abandoned by reset is never
// answered as far as this stage is concerned; rvalid seen while nothing is
// outstanding is ignored.
module f_stage #(
    parameter logic [31:0] RESET_PC = rv_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = rv_pkg::NOP_INST
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_rvalid,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          inst,
    output logic [31:0]          pc_out,
    output logic                 valid_out,
    output rv_pkg::fetch_state_t dbg_state
);

    import rv_pkg::*;

    // FSM state and fetch bookkeeping.
    fetch_state_t state_q;
    logic [31:0]  pc_q;          // next address to fetch
    logic [31:0]  fetch_pc_q;    // address of the outstanding request

    // Hold buffer; its "full" flag is the HOLD state itself.
    logic [31:0]  hold_inst_q;
    logic [31:0]  hold_pc_q;

    // IF/ID pipeline register.
    logic [31:0]  inst_q;
    logic [31:0]  pc_out_q;
    logic         valid_q;

    // Derived control.
    logic         req_outstanding;
    logic         deliver_mem;
    logic         deliver_hold;
    logic [31:0]  seq_pc;
    logic [31:0]  redirect_target;

    // Decode of the current state and the candidate next addresses.
    always_comb begin
        req_outstanding = (state_q == WAIT) || (state_q == DRAIN);
        // A wanted response goes straight to IF/ID when decode is not stalled.
        deliver_mem     = (state_q == WAIT) && imem_rvalid && !stall;
        // A parked response leaves the hold buffer once the stall drops.
        deliver_hold    = (state_q == HOLD) && !stall;
        // Sequential successor of the fetched word, wrapping at 2^32.
        seq_pc          = fetch_pc_q + 32'd4;
        // Low two bits of the target are ignored: fetches are word aligned.
        redirect_target = redirect_pc & 32'hFFFF_FFFC;
    end

    // Request pulse: only from IDLE, never in reset, and a redirect in the
    // same cycle wins so the stale pc is never fetched.
    assign imem_req  = rst_n && (state_q == IDLE) && !redirect;
    assign imem_addr = pc_q;

    assign inst      = inst_q;
    assign pc_out    = pc_out_q;
    assign valid_out = valid_q;
    assign dbg_state = state_q;

    // Fetch FSM together with pc, hold buffer and the IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= 32'h0;
            hold_inst_q <= 32'h0;
            hold_pc_q   <= 32'h0;
            inst_q      <= NOP_INST;
            pc_out_q    <= 32'h0;
            valid_q     <= 1'b0;
        end else if (redirect) begin
            // Redirect overrides stall: flush IF/ID, drop any parked word and
            // restart at the target. An in-flight request that is not being
            // answered this cycle still has to be drained.
            inst_q      <= NOP_INST;
            valid_q     <= 1'b0;
            pc_q        <= redirect_target;
            hold_inst_q <= 32'h0;
            hold_pc_q   <= 32'h0;
            if (req_outstanding && !imem_rvalid) begin
                state_q <= DRAIN;
            end else begin
                state_q <= IDLE;
            end
        end else begin
            // IF/ID update: deliver, bubble, or hold under stall.
            if (!stall) begin
                if (deliver_mem) begin
                    inst_q   <= imem_rdata;
                    pc_out_q <= fetch_pc_q;
                    valid_q  <= 1'b1;
                end else if (deliver_hold) begin
                    inst_q   <= hold_inst_q;
                    pc_out_q <= hold_pc_q;
                    valid_q  <= 1'b1;
                end else begin
                    inst_q   <= NOP_INST;
                    valid_q  <= 1'b0;
                end
            end

            // State transitions and fetch bookkeeping.
            case (state_q)
                IDLE: begin
                    // imem_req is high here; rvalid in IDLE is ignored.
                    fetch_pc_q <= pc_q;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        pc_q <= seq_pc;
                        if (stall) begin
                            hold_inst_q <= imem_rdata;
                            hold_pc_q   <= fetch_pc_q;
                            state_q     <= HOLD;
                        end else begin
                            state_q     <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    // rvalid in HOLD is ignored; leave once the word is taken.
                    if (!stall) begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f_stage.sv
// Bench for f_stage: directed scenarios with hand-computed expectations, a
// 1/3-cycle latency memory model, and an abstract fetch model that checks
// the IF/ID outputs and the request port on every falling edge.
module tb_f_stage;
  import rv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset / DUT signals ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stall = 1'b0;
  logic         redirect = 1'b0;
  logic [31:0]  redirect_pc = 32'h0;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_rvalid = 1'b0;
  logic [31:0]  imem_rdata = 32'h0;
  logic [31:0]  inst;
  logic [31:0]  pc_out;
  logic         valid_out;
  fetch_state_t dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  f_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .pc_out      (pc_out),
    .valid_out   (valid_out),
    .dbg_state   (dbg_state)
  );

  // ---------------- helpers ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus state and memory model ----------------
  logic        s_rst = 1'b0;
  logic        s_stall = 1'b0;
  logic        s_redirect = 1'b0;
  logic [31:0] s_rpc = 32'h0;
  logic        s_stale = 1'b0;
  int          lat = 1;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt = 0;

  // One clock cycle: drive inputs just after the rising edge, then let the
  // memory latch a request seen in this cycle.
  task automatic cycle();
    @(posedge clk);
    #1;
    rst_n = s_rst;
    if (!s_rst) mem_pend = 1'b0;
    if (s_stale) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (mem_pend && mem_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_addr);
      mem_pend    = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (mem_pend) mem_cnt--;
    end
    stall       = s_stall;
    redirect    = s_redirect;
    redirect_pc = s_rpc;
    #1;
    if (imem_req) begin
      chk("single_outstanding", {31'b0, mem_pend}, 32'd0);
      mem_pend = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = lat - 1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_req(input string name, input logic [31:0] addr, input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (imem_req) begin
        chk(name, imem_addr, addr);
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: no imem_req within %0d cycles, required addr %h", name, budget, addr);
  endtask

  // ---------------- abstract fetch model + per-cycle compare ----------------
  // exp_q holds words that came back and are owed to decode, as {pc, inst}.
  logic [63:0] exp_q[$];
  logic        m_out = 1'b0;        // a request is in flight
  logic        m_want = 1'b0;       // its answer is still wanted
  logic [31:0] m_fpc = 32'h0;
  logic [31:0] m_next_pc = 32'h0;
  logic [31:0] e_inst = NOP;
  logic [31:0] e_pc = 32'h0;
  logic        e_valid = 1'b0;
  logic        exp_req;
  logic [63:0] ent;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_out = 1'b0; m_want = 1'b0; m_fpc = 32'h0; m_next_pc = 32'h0;
        e_inst = NOP; e_pc = 32'h0; e_valid = 1'b0;
      end
      chk("m_inst", inst, e_inst);
      chk("m_pc_out", pc_out, e_pc);
      chk("m_valid_out", {31'b0, valid_out}, {31'b0, e_valid});
      exp_req = rst_n && !m_out && (exp_q.size() == 0) && !redirect;
      chk("m_imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req && imem_req) chk("m_imem_addr", imem_addr, m_next_pc);
      if (rst_n) begin
        if (redirect) begin
          e_inst = NOP; e_valid = 1'b0;
          exp_q.delete();
          if (imem_rvalid && m_out) m_out = 1'b0;
          m_want = 1'b0;
          m_next_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
          if (imem_rvalid && m_out) begin
            m_out = 1'b0;
            if (m_want) begin
              exp_q.push_back({m_fpc, imem_rdata});
              m_next_pc = m_fpc + 32'd4;
            end
          end
          if (!stall) begin
            if (exp_q.size() > 0) begin
              ent = exp_q.pop_front();
              e_pc = ent[63:32]; e_inst = ent[31:0]; e_valid = 1'b1;
            end else begin
              e_inst = NOP; e_valid = 1'b0;
            end
          end
          if (exp_req) begin
            m_out = 1'b1; m_want = 1'b1; m_fpc = m_next_pc;
          end
        end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    // Reset values.
    s_rst = 1'b0;
    run(3);
    chk("rst_inst", inst, NOP);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);

    // First fetch, 1-cycle memory.
    s_rst = 1'b1;
    wait_req("first_req_addr", 32'h0, 1);
    cycle();
    cycle();
    chk("first_inst", inst, 32'h0010_0093);
    chk("first_pc_out", pc_out, 32'h0);
    chk("first_valid", {31'b0, valid_out}, 32'd1);
    chk("second_req", {31'b0, imem_req}, 32'd1);
    chk("second_addr", imem_addr, 32'h4);

    // Stall for 3 cycles across the response for 0x8.
    cycle();
    s_stall = 1'b1;
    run(3);
    chk("stall_inst", inst, mem_word(32'h4));
    chk("stall_pc_out", pc_out, 32'h4);
    chk("stall_valid", {31'b0, valid_out}, 32'd1);
    chk("stall_no_req", {31'b0, imem_req}, 32'd0);
    chk("stall_state", 32'(dbg_state), 32'(HOLD));
    s_stall = 1'b0;
    run(2);
    chk("release_inst", inst, mem_word(32'h8));
    chk("release_pc_out", pc_out, 32'h8);
    chk("release_next_addr", imem_addr, 32'hC);

    // Redirect while WAIT, response two cycles later is dropped.
    lat = 3;
    wait_req("pre_redirect_addr", 32'h10, 4);
    s_redirect = 1'b1; s_rpc = 32'h100;
    cycle();
    s_redirect = 1'b0;
    cycle();
    chk("redir_bubble_valid", {31'b0, valid_out}, 32'd0);
    chk("redir_bubble_inst", inst, NOP);
    chk("redir_drain_state", 32'(dbg_state), 32'(DRAIN));
    chk("redir_drain_no_req", {31'b0, imem_req}, 32'd0);
    wait_req("redir_target_addr", 32'h100, 3);

    // Redirect together with stall while HOLD.
    s_stall = 1'b1;
    run(4);
    chk("hold_no_req", {31'b0, imem_req}, 32'd0);
    s_redirect = 1'b1; s_rpc = 32'h203;
    cycle();
    s_redirect = 1'b0; s_stall = 1'b0;
    lat = 1;
    cycle();
    chk("hold_redir_valid", {31'b0, valid_out}, 32'd0);
    chk("hold_redir_inst", inst, NOP);
    chk("hold_redir_req", {31'b0, imem_req}, 32'd1);
    chk("hold_redir_addr", imem_addr, 32'h200);

    // Wrap from 0xFFFFFFFC to 0x0.
    run(3);
    s_redirect = 1'b1; s_rpc = 32'hFFFF_FFFC;
    cycle();
    s_redirect = 1'b0;
    wait_req("wrap_top_addr", 32'hFFFF_FFFC, 3);
    cycle();
    wait_req("wrap_zero_addr", 32'h0, 3);
    chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
    chk("wrap_inst", inst, mem_word(32'hFFFF_FFFC));

    // Reset mid-WAIT, then a stale rvalid while IDLE.
    lat = 3;
    wait_req("pre_reset_addr", 32'h4, 3);
    cycle();
    s_rst = 1'b0;
    cycle();
    chk("async_rst_inst", inst, NOP);
    chk("async_rst_pc_out", pc_out, 32'h0);
    chk("async_rst_valid", {31'b0, valid_out}, 32'd0);
    chk("async_rst_req", {31'b0, imem_req}, 32'd0);
    cycle();
    s_rst = 1'b1; s_stale = 1'b1;
    cycle();
    s_stale = 1'b0;
    chk("post_rst_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    run(4);
    chk("post_rst_inst", inst, 32'h0010_0093);
    chk("post_rst_pc_out", pc_out, 32'h0);
    chk("post_rst_valid", {31'b0, valid_out}, 32'd1);

    run(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
